mode_decoder_sync: RTL

Clocked, parametrised successor to the combinational mode decoder. It samples an N-bit mode code and debounces it, committing only after the code has held stable for a programmable number of cycles. It then drives a registered one-hot mode bus, the binary index, and single-cycle change/illegal strobes. It sits between the mode-select inputs and the mode-dependent datapath logic, so downstream blocks never see glitching or out-of-range modes.

---
 rtl/mode_decoder_sync.sv | 107 ++++++++++
 1 files changed

// File: rtl/mode_decoder_sync.sv
// Debounced mode decoder: a sampled mode code must hold for STABLE_CYCLES+1
// consecutive qualifying samples before it drives the registered one-hot/index outputs.
//
// state | meaning
// IDLE  | committed mode matches the sampled code, or sampling is disabled
// QUAL  | a differing code is being counted toward commit or illegal flag
module mode_decoder_sync #(
  parameter int CODE_W        = 4,
  parameter int NUM_MODES     = 10,
  parameter int STABLE_CYCLES = 4,
  parameter int DEFAULT_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CODE_W-1:0]    mode_d,
  output logic [NUM_MODES-1:0] mode_a,
  output logic [CODE_W-1:0]    mode_idx,
  output logic                 mode_chg,
  output logic                 illegal,
  output logic                 busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CODE_W-1:0]    DEF_CODE   = CODE_W'(DEFAULT_MODE);
  localparam logic [CODE_W:0]      NUM_LIM    = (CODE_W + 1)'(NUM_MODES);
  localparam logic [NUM_MODES-1:0] DEF_ONEHOT = NUM_MODES'(1) << DEFAULT_MODE;

  typedef enum logic {IDLE, QUAL} state_t;

  state_t            state, state_nxt;
  logic [CODE_W-1:0] mode_q;
  logic [CODE_W-1:0] cand, cand_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              do_commit, do_illegal;
  logic              cand_legal;

  assign cand_legal = ({1'b0, cand} < NUM_LIM);
  assign busy       = (state == QUAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= DEF_CODE;
      cand     <= DEF_CODE;
      cnt      <= '0;
      mode_idx <= DEF_CODE;
      mode_a   <= DEF_ONEHOT;
      mode_chg <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      cnt      <= cnt_nxt;
      mode_chg <= do_commit;
      illegal  <= do_illegal;
      if (en) mode_q <= mode_d;
      if (do_commit) begin
        mode_idx <= cand;
        mode_a   <= NUM_MODES'(1) << cand;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    do_commit  = 1'b0;
    do_illegal = 1'b0;
    case (state)
      IDLE: begin
        if (en && (mode_q != mode_idx)) begin
          state_nxt = QUAL;
          cand_nxt  = mode_q;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      QUAL: begin
        if (!en || (mode_q == mode_idx)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (mode_q != cand) begin
          // a different non-committed code restarts qualification on itself
          cand_nxt = mode_q;
          cnt_nxt  = CNT_ONE;
        end else if (cnt < CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          do_commit  = cand_legal;
          do_illegal = !cand_legal;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
